// File: rtl/dmem_pkg.sv
// Shared widths and state encoding for the data-memory responder.
package dmem_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } dmem_state_t;

endpackage

// File: rtl/dmem_line_ram.sv
// Synchronous single-port line array; rdata only updates on enabled reads,
// so it holds the last read line across writes and idle cycles.
module dmem_line_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [LINE_W-1:0]        wdata,
  output logic [LINE_W-1:0]        rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Array storage is deliberately unreset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency line read/write responder for the data-cache memory port.
// Optional DMEM_STATS_EN adds read/write completion counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
`ifdef DMEM_STATS_EN
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o,
`endif
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 8;

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic              write_q;
  logic              capture_c;
  logic              fire_c;
  logic              unused_addr_bits;

  // Offset bits and bits above the line index alias away.
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    fire_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          capture_c = 1'b1;
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          fire_c  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ack_o   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ack_o <= fire_c;
      if (capture_c) begin
        idx_q   <= addr_i[OFFSET_W +: IDX_W];
        data_q  <= data_i;
        write_q <= write_i;
      end
    end
  end

  // Commit or read happens on the same edge that raises ack_o.
  dmem_line_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (fire_c),
    .we    (write_q),
    .idx   (idx_q),
    .wdata (data_q),
    .rdata (data_o)
  );

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (fire_c) begin
      if (write_q) begin
        wr_cnt_o <= wr_cnt_o + 32'd1;
      end else begin
        rd_cnt_o <= rd_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, random ops vs a line model,
// reset aborts, held-enable pulse spacing and a LATENCY=1 instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned L  = 10;
  localparam int unsigned D  = 512;
  localparam int unsigned L1 = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr, addr1;
  logic [255:0] din, din1;
  logic         en, wr, en1, wr1;
  logic         ack, ack1;
  logic [255:0] dout, dout1;
`ifdef DMEM_STATS_EN
  logic [31:0]  rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  logic [255:0] mem_m [D];
  bit           valid_m [D];
  logic [255:0] last_rd;
  int           rd_m, wr_m;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(D), .LATENCY(L)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (din),
    .enable_i (en),
    .write_i  (wr),
`ifdef DMEM_STATS_EN
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt),
`endif
    .ack_o    (ack),
    .data_o   (dout)
  );

  dmem_responder #(.DEPTH(4), .LATENCY(L1)) u_dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr1),
    .data_i   (din1),
    .enable_i (en1),
    .write_i  (wr1),
`ifdef DMEM_STATS_EN
    .rd_cnt_o (rd_cnt1),
    .wr_cnt_o (wr_cnt1),
`endif
    .ack_o    (ack1),
    .data_o   (dout1)
  );

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % D);
  endfunction

  // One request on the main instance: latency, data at ack, single-cycle ack, data held.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d,
                        input logic [255:0] exp, input string name);
    int lat;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk);
    #1;
    lat = 0;
    en = 1'($urandom); wr = 1'($urandom); addr = $urandom; din = rnd_line();
    while (!ack && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    en = 1'b0;
    check({name, "_latency"}, 256'(lat), 256'(L));
    check({name, "_data"}, dout, exp);
    @(posedge clk);
    #1;
    check({name, "_ack_width"}, 256'(ack), 256'(0));
    check({name, "_data_hold"}, dout, exp);
  endtask

  task automatic model_apply(input bit w, input logic [31:0] a, input logic [255:0] d);
    if (w) begin
      mem_m[line_of(a)] = d;
      valid_m[line_of(a)] = 1'b1;
      wr_m++;
    end else begin
      last_rd = mem_m[line_of(a)];
      rd_m++;
    end
  endtask

  initial begin
    int cnt;
    int lat;
    int since;
    int pulses;
    logic [255:0] a5_line;
    logic [255:0] d_r;
    logic [31:0]  a_r;
    bit           w_r;

    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    last_rd = '0; rd_m = 0; wr_m = 0;
    a5_line = {32{8'hA5}};

    tbl[0] = '{1'b1, 32'h0000_0020, a5_line,           256'h0};
    tbl[1] = '{1'b0, 32'h0000_0020, 256'h0,            a5_line};
    tbl[2] = '{1'b1, 32'h0000_4020, 256'h1,            a5_line};
    tbl[3] = '{1'b0, 32'h0000_003F, 256'h0,            256'h1};
    tbl[4] = '{1'b1, 32'h0000_0040, 256'h5A5A,         256'h1};
    tbl[5] = '{1'b0, 32'h0000_0040, 256'h0,            256'h5A5A};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 256'(ack), 256'(0));
    check("reset_data", dout, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (ack) cnt++;
    end
    check("idle_no_ack", 256'(cnt), 256'(0));

    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("tbl%0d", i));
      model_apply(tbl[i].w, tbl[i].a, tbl[i].d);
    end

    // Reset during WAIT with cnt=3 must abort the write to 0x40.
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h40; din = 256'hFF;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ack", 256'(ack), 256'(0));
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (ack) cnt++;
    end
    check("abort_no_ack", 256'(cnt), 256'(0));
    check("abort_data_reset", dout, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0; rd_m = 0; wr_m = 0;
    do_req(1'b0, 32'h40, 256'h0, 256'h5A5A, "abort_readback");
    model_apply(1'b0, 32'h40, 256'h0);

    // Random ops with aliasing high bits and ignored offset bits.
    for (int i = 0; i < 60; i++) begin
      a_r = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
      w_r = 1'($urandom);
      if (!valid_m[line_of(a_r)]) w_r = 1'b1;
      d_r = rnd_line();
      model_apply(w_r, a_r, d_r);
      do_req(w_r, a_r, d_r, last_rd, $sformatf("rnd%0d", i));
    end
`ifdef DMEM_STATS_EN
    check("stats_rd", 256'(rd_cnt), 256'(rd_m));
    check("stats_wr", 256'(wr_cnt), 256'(wr_m));
`endif

    // LATENCY=1 instance: write then read back.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      en1 = 1'b1; wr1 = (k == 0); addr1 = 32'h20; din1 = 256'h77;
      @(posedge clk);
      #1;
      en1 = 1'b0;
      lat = 0;
      while (!ack1 && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("lat1_latency%0d", k), 256'(lat), 256'(L1));
      check($sformatf("lat1_data%0d", k), dout1, (k == 0) ? 256'h0 : 256'h77);
      @(posedge clk);
      #1;
      check($sformatf("lat1_ack_width%0d", k), 256'(ack1), 256'(0));
    end

    // Reset in the ACK cycle drops ack_o without waiting for a clock.
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h60; din = rnd_line();
    @(posedge clk);
    #1;
    en = 1'b0;
    lat = 0;
    while (!ack && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ack_seen_before_reset", 256'(ack), 256'(1));
    rst = 1'b1;
    #1;
    check("ack_drop_on_reset", 256'(ack), 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Held enable with reads: pulses every L+2 edges after the first L.
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h20;
    @(posedge clk);
    since = 0;
    pulses = 0;
    for (int i = 0; i < 200 && pulses < 3; i++) begin
      @(posedge clk);
      #1;
      since++;
      if (ack) begin
        pulses++;
        check($sformatf("held_spacing%0d", pulses), 256'(since), (pulses == 1) ? 256'(L) : 256'(L + 2));
        since = 0;
      end
    end
    en = 1'b0;
    check("held_pulses", 256'(pulses), 256'(3));
`ifdef DMEM_STATS_EN
    check("held_rd_cnt", 256'(rd_cnt), 256'(3));
    check("held_wr_cnt", 256'(wr_cnt), 256'(0));
`endif
    repeat (3) @(posedge clk);
    #1;
    check("held_quiet", 256'(ack), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data-cache refill/write-back port. It accepts one 256-bit line read or write request from the cache controller, waits a fixed access latency, then commits the write or returns the read line with a single-cycle acknowledge. It sits below the CPU's data cache in the system testbench and top level, and drives the cache's `mem_data_i` and `mem_ack_i` inputs.

## Interface
- `DEPTH`, default 512: number of 256-bit lines; power of two, at least 2.
- `LATENCY`, default 10: clock edges from request capture to acknowledge; 1 to 255.
- `clk_i`  in  1: the single clock.
- `rst_i`  in  1: reset, **asynchronous, active-high**.
- `addr_i`  in  32: byte address; bits [4:0] are ignored.
- `data_i`  in  256: write line.
- `enable_i`  in  1: request valid; the requester holds it until it sees `ack_o`.
- `write_i`  in  1: 1 selects write, 0 selects read; sampled with `enable_i`.
- `ack_o`  out  1: one-cycle completion pulse.
- `data_o`  out  256: read line.

## Operation
- States:
  - IDLE: if `enable_i`=1, latch `addr_i`, `data_i` and `write_i`, load `cnt`=LATENCY-1, and go to WAIT.
  - WAIT: if `cnt`≠0, decrement it; if `cnt`=0, go to ACK.
  - ACK: go to IDLE unconditionally.
- On the WAIT→ACK edge:
  - `ack_o` goes to 1.
  - A latched write stores `data_q` to `mem[idx]`.
  - A latched read loads `data_o` from `mem[idx]`.
- Line index: `idx` = `addr_q[5 +: log2(DEPTH)]`. Higher address bits are ignored, so addresses alias modulo DEPTH×32 bytes.
- `data_o` holds the last read line. It does not change on writes or in any other state.
- `enable_i` is ignored in WAIT and ACK.
  - Changes to the inputs during WAIT have no effect.
  - If `enable_i` is still high in the cycle after ACK, IDLE captures it as a new request. The requester must drop `enable_i` in the cycle after it sees `ack_o`.
- `write_i` is sampled at the capture edge only.
- Reset values:
  - State is IDLE.
  - `ack_o`=0, `data_o`=0, `cnt`=0.
- The line array is not reset; its contents are undefined until written.
- Reset asserted in WAIT or ACK aborts the request: no write is committed, and `ack_o` drops immediately.

## Timing
- Request captured at edge E0 (IDLE with `enable_i`=1).
- `ack_o` is registered high in the cycle following edge E0+LATENCY, and low at E0+LATENCY+1.
- Read data is valid in the same cycle as `ack_o`.
- Write data is visible to a read captured at E0+LATENCY+1 or later.
- Minimum request spacing is LATENCY+2 edges.
- LATENCY=1: WAIT lasts exactly one cycle.

## Configuration
- `DMEM_STATS_EN` defined:
  - Adds outputs `rd_cnt_o` and `wr_cnt_o`, each 32 bits, reset to 0.
  - The matching counter increments on the edge that raises `ack_o`.
  - Counters wrap modulo 2^32.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `dmem_pkg` holds:
  - `LINE_W`=256, `ADDR_W`=32, `OFFSET_W`=5.
  - The state enum `dmem_state_t` {IDLE, WAIT, ACK}.
- Sub-module `dmem_line_ram`: a synchronous single-port DEPTH×256 array with `we`, `idx`, `wdata` and `rdata`, read and write on the same edge. The responder FSM, counter and latches stay in the top module.

## Test plan
- Reset hold then release:
  - `ack_o`=0 and `data_o`=0.
  - No `ack_o` for 50 cycles with `enable_i`=0.
- Write, then read back:
  - Write `data_i`=256'hA5…A5 to 0x0000_0020.
  - Read 0x0000_0020 → `data_o`=256'hA5…A5 in the `ack_o` cycle.
- Latency with LATENCY=10:
  - Capture at edge 0 → `ack_o` high only after edge 10.
  - Repeat with LATENCY=1 → `ack_o` after edge 1.
- Alias with DEPTH=512:
  - Write 256'h1 to 0x0000_4020.
  - Read 0x0000_0020 → 256'h1.
  - `addr_i` bits [4:0]=5'h1F are ignored.
- Reset mid-operation:
  - Assert `rst_i` at WAIT `cnt`=3 of a write of 256'hFF to 0x40.
  - → no `ack_o`; a later read of 0x40 returns the prior contents.
- Held `enable_i` with `DMEM_STATS_EN` defined:
  - Keep `enable_i`=1 with `write_i`=0 → `ack_o` pulses every LATENCY+2 cycles.
  - `rd_cnt_o`=3 after the third pulse; `wr_cnt_o`=0.
